// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - grants the shared VGA pixel port to the four draw FSMs in turn.
// Optional DRAW_TIMEOUT_EN: force-retire a job that never signals done and flag timeout_err.
module draw_scheduler #(
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int TO_W           = 19
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_screen,
  input  logic       req_money,
  input  logic       req_action,
  input  logic       req_gameover,
  input  logic       abort,
  input  logic       done_s,
  input  logic       done_m,
  input  logic       done_a,
  input  logic       done_g,
  output logic       go_screen,
  output logic       go_money,
  output logic       go_action,
  output logic       go_gameover,
  output logic [1:0] grant_sel,
  output logic       busy,
  output logic [3:0] pending,
  output logic       frame_done,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d, clr, req_vec, done_vec, go_vec;
  logic [1:0] grant_q, grant_d, winner;
  logic       frame_done_q, frame_done_d;
  logic       done_match, to_hit, retire;

  // Bit order everywhere is {gameover, action, money, screen}, matching grant_sel encoding.
  assign req_vec    = {req_gameover, req_action, req_money, req_screen};
  assign done_vec   = {done_g, done_a, done_m, done_s};
  assign done_match = done_vec[grant_q];
  assign retire     = done_match | to_hit;

  always_comb begin
    if (pending_q[3])      winner = 2'd3;
    else if (pending_q[0]) winner = 2'd0;
    else if (pending_q[1]) winner = 2'd1;
    else                   winner = 2'd2;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    clr          = 4'b0000;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending_q != 4'b0000) begin
          state_d = S_ISSUE;
          grant_d = winner;
          clr     = 4'b0001 << winner;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (retire) begin
          state_d      = S_IDLE;
          frame_done_d = ((pending_q | req_vec) == 4'b0000);
        end
      end
      default: state_d = S_IDLE;
    endcase
    pending_d = (pending_q & ~clr) | req_vec;
    if (abort) begin
      state_d      = S_IDLE;
      pending_d    = 4'b0000;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      pending_q    <= 4'b0000;
      grant_q      <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DRAW_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  assign to_hit = (state_q == S_WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == S_ISSUE)     to_cnt_d = '0;
    else if (state_q == S_WAIT) to_cnt_d = to_cnt_q + TO_W'(1);
    timeout_err_d = timeout_err_q | (to_hit & ~done_match);
    if (abort) timeout_err_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  wire unused_cfg = (TIMEOUT_CYCLES > 0) && (TO_W > 0);
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // go is decoded from state so it lines up exactly with the ISSUE cycle.
  assign go_vec      = ((state_q == S_ISSUE) && !abort) ? (4'b0001 << grant_q) : 4'b0000;
  assign go_screen   = go_vec[0];
  assign go_money    = go_vec[1];
  assign go_action   = go_vec[2];
  assign go_gameover = go_vec[3];
  assign grant_sel   = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign pending     = pending_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - scoreboard bench for draw_scheduler (go/frame_done event ordering and timing).
module tb_draw_scheduler;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       req_screen = 0, req_money = 0, req_action = 0, req_gameover = 0, abort = 0;
  logic       done_s = 0, done_m = 0, done_a = 0, done_g = 0;
  logic       go_screen, go_money, go_action, go_gameover;
  logic [1:0] grant_sel;
  logic       busy, frame_done, timeout_err;
  logic [3:0] pending;

  draw_scheduler #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clock(clock), .resetn(resetn),
    .req_screen(req_screen), .req_money(req_money), .req_action(req_action), .req_gameover(req_gameover),
    .abort(abort), .done_s(done_s), .done_m(done_m), .done_a(done_a), .done_g(done_g),
    .go_screen(go_screen), .go_money(go_money), .go_action(go_action), .go_gameover(go_gameover),
    .grant_sel(grant_sel), .busy(busy), .pending(pending), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // code 0..3 = go for that FSM, 4 = frame_done; cyc < 0 means any cycle
  typedef struct {int code; int cyc;} ev_t;
  ev_t exp_q[$];
  int  total = 0, bad = 0, cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int code, input int c);
    ev_t e;
    e.code = code;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every go pulse / frame_done pulse is popped and compared against the scoreboard.
  always @(negedge clock) begin
    logic [3:0] g;
    int code;
    ev_t e;
    g = {go_gameover, go_action, go_money, go_screen};
    if (resetn && (g != 4'b0 || frame_done)) begin
      if (frame_done) code = 4;
      else if (g == 4'b0001) code = 0;
      else if (g == 4'b0010) code = 1;
      else if (g == 4'b0100) code = 2;
      else if (g == 4'b1000) code = 3;
      else code = 99;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", code, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("event_code", code, e.code);
        if (code < 4) chk("event_grant_sel", {30'b0, grant_sel}, e.code);
        if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_go();
    int i;
    for (i = 0; i < 20; i++) begin
      if ({go_gameover, go_action, go_money, go_screen} != 4'b0) break;
      step();
    end
    if (i == 20) chk("go_timeout", 0, 1);
  endtask

  task automatic pulse_done(input int k);
    {done_g, done_a, done_m, done_s} = 4'b0001 << k;
    step();
    {done_g, done_a, done_m, done_s} = 4'b0000;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    {req_gameover, req_action, req_money, req_screen} = r;
    step();
    {req_gameover, req_action, req_money, req_screen} = 4'b0000;
  endtask

  initial begin
    int c0;
    #3;
    chk("reset_outputs",
        {21'b0, go_gameover, go_action, go_money, go_screen, grant_sel, busy, pending, frame_done, timeout_err},
        32'h0);
    step();
    resetn = 1'b1;
    step();

    // 1: money request, timed
    c0 = cyc;
    expect_ev(1, c0 + 2);
    expect_ev(4, c0 + 11);
    pulse_req(4'b0010);
    chk("t1_pending", pending, 4'b0010);
    while (cyc < c0 + 10) step();
    pulse_done(1);
    step();
    chk("t1_idle", busy, 0);

    // 2: three simultaneous requests served gameover, screen, action
    expect_ev(3, -1); expect_ev(0, -1); expect_ev(2, -1); expect_ev(4, -1);
    pulse_req(4'b1101);
    wait_go(); step(); pulse_done(3);
    wait_go(); step(); pulse_done(0);
    wait_go(); step(); pulse_done(2);
    step(); step();
    chk("t2_idle", busy, 0);

    // 3: foreign done ignored during screen WAIT
    expect_ev(0, -1); expect_ev(4, -1);
    pulse_req(4'b0001);
    wait_go(); step();
    {done_m, done_a} = 2'b11;
    step();
    {done_m, done_a} = 2'b00;
    step();
    chk("t3_still_busy", busy, 1);
    chk("t3_grant", grant_sel, 2'd0);
    pulse_done(0);
    step();
    chk("t3_retired", busy, 0);

    // 4: re-request during WAIT runs the job again
    expect_ev(0, -1); expect_ev(0, -1); expect_ev(4, -1);
    pulse_req(4'b0001);
    wait_go(); step();
    pulse_req(4'b0001);
    chk("t4_pending_set", pending, 4'b0001);
    pulse_done(0);
    wait_go();
    chk("t4_pending_clr", pending, 4'b0000);
    step(); pulse_done(0);
    step(); step();

    // 5: abort in WAIT with a simultaneous request
    expect_ev(1, -1);
    pulse_req(4'b0010);
    wait_go(); step();
    abort = 1'b1; req_money = 1'b1;
    step();
    abort = 1'b0; req_money = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_pending", pending, 4'b0000);
    repeat (4) step();
    chk("t5_still_idle", busy, 0);

`ifdef DRAW_TIMEOUT_EN
    // 6: timeout retire, then async reset mid-WAIT
    expect_ev(2, -1); expect_ev(4, -1);
    pulse_req(4'b0100);
    wait_go(); step();
    c0 = cyc;
    while (busy && cyc < c0 + 40) step();
    chk("t6_retire_cycles", cyc - c0, 16);
    chk("t6_timeout_err", timeout_err, 1);
    expect_ev(0, -1);
    pulse_req(4'b0001);
    wait_go(); step(); step();
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_reset",
        {21'b0, go_gameover, go_action, go_money, go_screen, grant_sel, busy, pending, frame_done, timeout_err},
        32'h0);
    step();
    resetn = 1'b1;
    step();
`endif

    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
